// File: rtl/core_config_controller.sv
// core_config_controller
//
// Double-buffered parameter store for the FM synthesis core. The host writes
// per-operator parameters into a shadow bank. A commit request then copies the
// whole shadow bank into the live bank on a single clock edge. That edge is the
// one that samples i_SampleReady while a commit is pending, so the core never
// renders a sample from a mix of old and new settings.
//
// Ports
//   i_Clock, i_Reset       clock; synchronous active-low reset
//   i_WriteValid/o_WriteReady, i_WriteVoice/Operator/Field/Data
//                          host write port into the shadow bank
//                          field: 0 PhaseStep, 1 EnvelopeLevel,
//                                 2 Waveform (data bit 0), 3 reserved
//   o_WriteError           one-cycle pulse after an accepted illegal write
//                          (operator >= NUM_OPERATORS or field 3)
//   i_Commit               request a shadow -> live copy
//   i_SampleReady          core's last-subsample indicator (sample boundary)
//   o_CommitPending        commit waiting for a sample boundary
//   o_CommitDone           one-cycle pulse after the copy
//   i_ReadValid, i_ReadVoice/Operator/Field -> o_ReadValid, o_ReadData
//                          registered live-bank readback, one cycle of latency
//   o_Config               flattened live bank. Entry e = voice*NUM_OPERATORS+op
//                          sits at o_Config[e*33 +: 33] as
//                          {PhaseStep[15:0], EnvelopeLevel[15:0], Waveform}
module core_config_controller #(
    parameter int NUM_VOICES    = 16,
    parameter int NUM_OPERATORS = 6
) (
    input  logic                                       i_Clock,
    input  logic                                       i_Reset,
    input  logic                                       i_WriteValid,
    output logic                                       o_WriteReady,
    input  logic [3:0]                                 i_WriteVoice,
    input  logic [2:0]                                 i_WriteOperator,
    input  logic [1:0]                                 i_WriteField,
    input  logic [15:0]                                i_WriteData,
    output logic                                       o_WriteError,
    input  logic                                       i_Commit,
    input  logic                                       i_SampleReady,
    output logic                                       o_CommitPending,
    output logic                                       o_CommitDone,
    input  logic                                       i_ReadValid,
    input  logic [3:0]                                 i_ReadVoice,
    input  logic [2:0]                                 i_ReadOperator,
    input  logic [1:0]                                 i_ReadField,
    output logic                                       o_ReadValid,
    output logic [15:0]                                o_ReadData,
    output logic [NUM_VOICES*NUM_OPERATORS*33-1:0]     o_Config
);

    localparam int NUM_ENTRIES = NUM_VOICES * NUM_OPERATORS;
    localparam int ENTRY_W     = 33;
    localparam int IDX_W       = $clog2(NUM_ENTRIES);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [0:0]  state_reg;
    logic [0:0]  state_next;
    logic        write_ready_reg;
    logic        write_error_reg;
    logic        commit_done_reg;
    logic        read_valid_reg;
    logic [15:0] read_data_reg;

    logic             write_accept;
    logic             write_legal;
    logic             write_store;
    logic [IDX_W-1:0] write_idx;
    logic             copy_now;

    logic                          read_legal;
    logic [IDX_W-1:0]              read_idx;
    logic [ENTRY_W-1:0]            read_entry;
    logic [15:0]                   read_word;
    logic [NUM_ENTRIES*ENTRY_W-1:0] live_flat;

    function automatic logic [IDX_W-1:0] entry_idx(input logic [3:0] voice,
                                                   input logic [2:0] op);
        return IDX_W'(voice) * IDX_W'(NUM_OPERATORS) + IDX_W'(op);
    endfunction

    // Write decode. Illegal writes still handshake but never touch storage.
    assign write_accept = i_WriteValid && write_ready_reg;
    assign write_legal  = (i_WriteOperator < 3'(NUM_OPERATORS)) && (i_WriteField != 2'd3);
    assign write_store  = write_accept && write_legal;
    assign write_idx    = entry_idx(i_WriteVoice, i_WriteOperator);

    // The copy edge is the one sampling a sample boundary while pending; a
    // boundary seen in the same cycle as the commit request is not used.
    assign copy_now = (state_reg == ST_PENDING) && i_SampleReady;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (i_Commit)      state_next = ST_PENDING;
            ST_PENDING: if (i_SampleReady) state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    // Per-entry shadow and live storage. The whole bank must move on one
    // edge, so each entry is a plain register pair rather than RAM.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            logic [15:0] shadow_phase_reg;
            logic [15:0] shadow_level_reg;
            logic        shadow_wave_reg;
            logic [15:0] live_phase_reg;
            logic [15:0] live_level_reg;
            logic        live_wave_reg;
            logic        write_hit;

            assign write_hit = write_store && (write_idx == IDX_W'(gi));

            always_ff @(posedge i_Clock) begin
                if (!i_Reset) begin
                    shadow_phase_reg <= '0;
                    shadow_level_reg <= '0;
                    shadow_wave_reg  <= 1'b0;
                    live_phase_reg   <= '0;
                    live_level_reg   <= '0;
                    live_wave_reg    <= 1'b0;
                end else begin
                    if (write_hit) begin
                        case (i_WriteField)
                            2'd0:    shadow_phase_reg <= i_WriteData;
                            2'd1:    shadow_level_reg <= i_WriteData;
                            2'd2:    shadow_wave_reg  <= i_WriteData[0];
                            default: ;
                        endcase
                    end
                    if (copy_now) begin
                        live_phase_reg <= shadow_phase_reg;
                        live_level_reg <= shadow_level_reg;
                        live_wave_reg  <= shadow_wave_reg;
                    end
                end
            end

            assign live_flat[gi*ENTRY_W +: ENTRY_W] = {live_phase_reg, live_level_reg, live_wave_reg};
        end
    endgenerate

    // Readback mux over the live bank; illegal addresses read as zero.
    always_comb begin
        read_legal = (i_ReadOperator < 3'(NUM_OPERATORS)) && (i_ReadField != 2'd3);
        read_idx   = read_legal ? entry_idx(i_ReadVoice, i_ReadOperator) : '0;
        read_entry = live_flat[int'(read_idx)*ENTRY_W +: ENTRY_W];
        read_word  = '0;
        if (read_legal) begin
            case (i_ReadField)
                2'd0:    read_word = read_entry[32:17];
                2'd1:    read_word = read_entry[16:1];
                2'd2:    read_word = {15'd0, read_entry[0]};
                default: read_word = '0;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            state_reg       <= ST_IDLE;
            write_ready_reg <= 1'b0;
            write_error_reg <= 1'b0;
            commit_done_reg <= 1'b0;
            read_valid_reg  <= 1'b0;
            read_data_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            // Ready is registered so it stays low through reset and drops the
            // cycle a commit becomes pending.
            write_ready_reg <= (state_next == ST_IDLE);
            write_error_reg <= write_accept && !write_legal;
            commit_done_reg <= copy_now;
            read_valid_reg  <= i_ReadValid;
            if (i_ReadValid) begin
                read_data_reg <= read_word;
            end
        end
    end

    assign o_WriteReady    = write_ready_reg;
    assign o_WriteError    = write_error_reg;
    assign o_CommitPending = (state_reg == ST_PENDING);
    assign o_CommitDone    = commit_done_reg;
    assign o_ReadValid     = read_valid_reg;
    assign o_ReadData      = read_data_reg;
    assign o_Config        = live_flat;

endmodule

// File: tb/tb_core_config_controller.sv
// Testbench for core_config_controller: directed scenarios followed by a
// random phase, all checked each cycle against a bank-level reference model.
module tb_core_config_controller;

    localparam int NV = 16;
    localparam int NO = 6;
    localparam int NE = NV * NO;
    localparam int EW = 33;

    logic              i_Clock = 1'b0;
    logic              i_Reset;
    logic              i_WriteValid;
    logic              o_WriteReady;
    logic [3:0]        i_WriteVoice;
    logic [2:0]        i_WriteOperator;
    logic [1:0]        i_WriteField;
    logic [15:0]       i_WriteData;
    logic              o_WriteError;
    logic              i_Commit;
    logic              i_SampleReady;
    logic              o_CommitPending;
    logic              o_CommitDone;
    logic              i_ReadValid;
    logic [3:0]        i_ReadVoice;
    logic [2:0]        i_ReadOperator;
    logic [1:0]        i_ReadField;
    logic              o_ReadValid;
    logic [15:0]       o_ReadData;
    logic [NE*EW-1:0]  o_Config;

    always #5 i_Clock = ~i_Clock;

    core_config_controller #(.NUM_VOICES(NV), .NUM_OPERATORS(NO)) dut (
        .i_Clock         (i_Clock),
        .i_Reset         (i_Reset),
        .i_WriteValid    (i_WriteValid),
        .o_WriteReady    (o_WriteReady),
        .i_WriteVoice    (i_WriteVoice),
        .i_WriteOperator (i_WriteOperator),
        .i_WriteField    (i_WriteField),
        .i_WriteData     (i_WriteData),
        .o_WriteError    (o_WriteError),
        .i_Commit        (i_Commit),
        .i_SampleReady   (i_SampleReady),
        .o_CommitPending (o_CommitPending),
        .o_CommitDone    (o_CommitDone),
        .i_ReadValid     (i_ReadValid),
        .i_ReadVoice     (i_ReadVoice),
        .i_ReadOperator  (i_ReadOperator),
        .i_ReadField     (i_ReadField),
        .o_ReadValid     (o_ReadValid),
        .o_ReadData      (o_ReadData),
        .o_Config        (o_Config)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: two banks plus the externally visible status.
    logic [15:0] s_ph [NE];
    logic [15:0] s_env[NE];
    logic        s_wv [NE];
    logic [15:0] l_ph [NE];
    logic [15:0] l_env[NE];
    logic        l_wv [NE];
    bit          m_pending, m_ready, m_done, m_err, m_rvalid;
    logic [15:0] m_rdata;

    function automatic logic [15:0] model_read(int v, int op, int f);
        int e;
        if (op >= NO || f == 3) return 16'd0;
        e = v * NO + op;
        case (f)
            0:       return l_ph[e];
            1:       return l_env[e];
            default: return {15'd0, l_wv[e]};
        endcase
    endfunction

    task automatic model_edge();
        bit accept, legal;
        int e;
        if (!i_Reset) begin
            for (int k = 0; k < NE; k++) begin
                s_ph[k] = 0; s_env[k] = 0; s_wv[k] = 0;
                l_ph[k] = 0; l_env[k] = 0; l_wv[k] = 0;
            end
            m_pending = 0; m_ready = 0; m_done = 0; m_err = 0;
            m_rvalid = 0; m_rdata = 0;
            return;
        end
        accept = i_WriteValid && m_ready;
        legal  = (int'(i_WriteOperator) < NO) && (i_WriteField != 2'd3);
        m_done = m_pending && i_SampleReady;
        m_err  = accept && !legal;
        m_rvalid = i_ReadValid;
        if (i_ReadValid)
            m_rdata = model_read(int'(i_ReadVoice), int'(i_ReadOperator), int'(i_ReadField));
        if (m_done) begin
            for (int k = 0; k < NE; k++) begin
                l_ph[k] = s_ph[k]; l_env[k] = s_env[k]; l_wv[k] = s_wv[k];
            end
        end
        if (accept && legal) begin
            e = int'(i_WriteVoice) * NO + int'(i_WriteOperator);
            case (i_WriteField)
                2'd0:    s_ph[e]  = i_WriteData;
                2'd1:    s_env[e] = i_WriteData;
                default: s_wv[e]  = i_WriteData[0];
            endcase
        end
        if (m_done) m_pending = 0;
        else if (!m_pending && i_Commit) m_pending = 1;
        m_ready = !m_pending;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int bad;
        logic [EW-1:0] exp_e;
        chk("write_ready", 32'(o_WriteReady), 32'(m_ready));
        chk("write_error", 32'(o_WriteError), 32'(m_err));
        chk("commit_pending", 32'(o_CommitPending), 32'(m_pending));
        chk("commit_done", 32'(o_CommitDone), 32'(m_done));
        chk("read_valid", 32'(o_ReadValid), 32'(m_rvalid));
        chk("read_data", 32'(o_ReadData), 32'(m_rdata));
        bad = -1;
        for (int k = 0; k < NE; k++) begin
            exp_e = {l_ph[k], l_env[k], l_wv[k]};
            if (bad < 0 && o_Config[k*EW +: EW] !== exp_e) bad = k;
        end
        checks++;
        assert (bad < 0) else begin
            errors++;
            exp_e = {l_ph[bad], l_env[bad], l_wv[bad]};
            $error("FAIL config entry %0d observed=%0h expected=%0h",
                   bad, o_Config[bad*EW +: EW], exp_e);
        end
    endtask

    task automatic tick();
        @(posedge i_Clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_write(int v, int op, int f, logic [15:0] d);
        i_WriteValid = 1; i_WriteVoice = 4'(v); i_WriteOperator = 3'(op);
        i_WriteField = 2'(f); i_WriteData = d;
        tick();
        i_WriteValid = 0;
    endtask

    task automatic do_read(int v, int op, int f);
        i_ReadValid = 1; i_ReadVoice = 4'(v); i_ReadOperator = 3'(op); i_ReadField = 2'(f);
        tick();
        i_ReadValid = 0;
    endtask

    task automatic commit_and_copy();
        i_Commit = 1; tick(); i_Commit = 0;
        repeat (3) tick();
        i_SampleReady = 1; tick(); i_SampleReady = 0;
    endtask

    int ph_base;

    initial begin
        i_Reset = 0; i_WriteValid = 0; i_WriteVoice = 0; i_WriteOperator = 0;
        i_WriteField = 0; i_WriteData = 0; i_Commit = 0; i_SampleReady = 0;
        i_ReadValid = 0; i_ReadVoice = 0; i_ReadOperator = 0; i_ReadField = 0;

        // Reset and first cycle after release
        repeat (3) tick();
        chk("reset_ready_low", 32'(o_WriteReady), 32'd0);
        i_Reset = 1;
        tick();
        chk("ready_after_reset", 32'(o_WriteReady), 32'd1);
        do_read(3, 2, 0);
        chk("reset_readback", 32'(o_ReadData), 32'd0);

        // Basic commit
        ph_base = (5 * NO + 1) * EW + 17;
        do_write(5, 1, 0, 16'h1234);
        i_Commit = 1; tick(); i_Commit = 0;
        chk("basic_pending", 32'(o_CommitPending), 32'd1);
        repeat (39) tick();
        chk("basic_cfg_before", 32'(o_Config[ph_base +: 16]), 32'd0);
        i_SampleReady = 1; tick(); i_SampleReady = 0;
        chk("basic_done", 32'(o_CommitDone), 32'd1);
        chk("basic_cfg_after", 32'(o_Config[ph_base +: 16]), 32'h1234);
        tick();
        chk("basic_done_one_cycle", 32'(o_CommitDone), 32'd0);
        do_read(5, 1, 0);
        chk("basic_readback", 32'(o_ReadData), 32'h1234);

        // Atomicity: write held while pending
        i_Commit = 1; tick(); i_Commit = 0;
        i_WriteValid = 1; i_WriteVoice = 2; i_WriteOperator = 3;
        i_WriteField = 1; i_WriteData = 16'h7FFF;
        repeat (10) begin
            tick();
            chk("atom_ready_low", 32'(o_WriteReady), 32'd0);
        end
        i_SampleReady = 1; tick(); i_SampleReady = 0;
        chk("atom_done", 32'(o_CommitDone), 32'd1);
        chk("atom_ready_back", 32'(o_WriteReady), 32'd1);
        tick();
        i_WriteValid = 0;
        do_read(2, 3, 1);
        chk("atom_not_live", 32'(o_ReadData), 32'd0);
        commit_and_copy();
        do_read(2, 3, 1);
        chk("atom_live_after_2nd", 32'(o_ReadData), 32'h7FFF);

        // Commit and sample boundary in the same cycle
        do_write(7, 5, 2, 16'hFFFF);
        i_Commit = 1; i_SampleReady = 1; tick(); i_Commit = 0; i_SampleReady = 0;
        chk("same_pending", 32'(o_CommitPending), 32'd1);
        chk("same_no_done", 32'(o_CommitDone), 32'd0);
        repeat (95) tick();
        chk("same_still_pending", 32'(o_CommitPending), 32'd1);
        i_SampleReady = 1; tick(); i_SampleReady = 0;
        chk("same_done_next", 32'(o_CommitDone), 32'd1);
        do_read(7, 5, 2);
        chk("same_wave_live", 32'(o_ReadData), 32'd1);

        // Invalid writes
        do_write(4, 6, 0, 16'hBEEF);
        chk("inv_op_err", 32'(o_WriteError), 32'd1);
        tick();
        chk("inv_err_one_cycle", 32'(o_WriteError), 32'd0);
        do_write(4, 2, 3, 16'hCAFE);
        chk("inv_field_err", 32'(o_WriteError), 32'd1);
        commit_and_copy();
        do_read(4, 6, 0);
        chk("inv_op_readback", 32'(o_ReadData), 32'd0);
        do_read(4, 2, 0);
        chk("inv_field_untouched", 32'(o_ReadData), 32'd0);

        // Reset while pending abandons the commit
        do_write(0, 0, 2, 16'h0001);
        i_Commit = 1; tick(); i_Commit = 0;
        repeat (5) tick();
        i_Reset = 0; tick(); i_Reset = 1;
        chk("rst_pending_clear", 32'(o_CommitPending), 32'd0);
        chk("rst_no_done", 32'(o_CommitDone), 32'd0);
        tick();
        i_SampleReady = 1; tick(); i_SampleReady = 0;
        chk("rst_no_late_done", 32'(o_CommitDone), 32'd0);
        do_read(0, 0, 2);
        chk("rst_wave_not_live", 32'(o_ReadData), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            i_Reset         = ($urandom_range(0, 499) != 0);
            i_WriteValid    = ($urandom_range(0, 1) == 1);
            i_WriteVoice    = 4'($urandom_range(0, 15));
            i_WriteOperator = 3'($urandom_range(0, 7));
            i_WriteField    = 2'($urandom_range(0, 3));
            i_WriteData     = 16'($urandom);
            i_Commit        = ($urandom_range(0, 15) == 0);
            i_SampleReady   = ($urandom_range(0, 19) == 0);
            i_ReadValid     = ($urandom_range(0, 1) == 1);
            i_ReadVoice     = 4'($urandom_range(0, 15));
            i_ReadOperator  = 3'($urandom_range(0, 7));
            i_ReadField     = 2'($urandom_range(0, 3));
            tick();
        end

        i_Reset = 1; i_WriteValid = 0; i_Commit = 0; i_SampleReady = 0; i_ReadValid = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_config_controller.md
# core_config_controller

Double-buffered configuration store and commit sequencer for the FM synthesis core. A host writes per-operator parameters into a shadow bank through a valid/ready port. On request, the block copies the whole shadow bank into the live bank that drives the core's `CoreConfig_t` input. The copy happens exactly at a sample boundary, so the core never renders a sample from a mix of old and new parameters.

## Interface
Parameters:
- `NUM_VOICES`, 16: voices per sample; voice address is 4 bits.
- `NUM_OPERATORS`, 6: operators per voice; operator address is 3 bits, so codes 6–7 are invalid.

Ports:
- `i_Clock` in 1: single clock.
- `i_Reset` in 1: reset, synchronous, active-low.
- `i_WriteValid` in 1: host write request.
- `o_WriteReady` out 1: write is accepted when valid and ready are both high.
- `i_WriteVoice` in 4: target voice.
- `i_WriteOperator` in 3: target operator.
- `i_WriteField` in 2: field select. 0 = PhaseStep, 1 = EnvelopeLevel, 2 = Waveform (data bit 0), 3 = reserved.
- `i_WriteData` in 16: field value.
- `o_WriteError` out 1: one-cycle pulse after an accepted write with operator ≥ 6 or field 3.
- `i_Commit` in 1: request to copy shadow to live.
- `i_SampleReady` in 1: the core's `o_SampleReady`, high during the last subsample slot of each sample.
- `o_CommitPending` out 1: a commit is waiting for a sample boundary.
- `o_CommitDone` out 1: one-cycle pulse after a copy.
- `i_ReadValid` in 1: live-bank readback request.
- `i_ReadVoice` in 4, `i_ReadOperator` in 3, `i_ReadField` in 2: readback address.
- `o_ReadValid` out 1: readback data valid.
- `o_ReadData` out 16: readback data.
- `o_Config` out `CoreConfig_t`: live bank, connected directly to the core's `i_Config`.

## Operation
- Storage consists of two banks, each 16 × 6 entries of {PhaseStep[15:0], EnvelopeLevel signed[15:0], Waveform[0]}.
- Writes update the shadow bank only. Invalid writes (operator ≥ 6 or field 3) are still accepted and handshaken, but are discarded and raise `o_WriteError`.
- The FSM has two states, IDLE and PENDING.
  - IDLE: `o_WriteReady` = 1. On `i_Commit` = 1, go to PENDING.
  - PENDING: `o_WriteReady` = 0 and `o_CommitPending` = 1. On `i_SampleReady` = 1, copy all shadow entries to live at that edge and return to IDLE.
- `i_Commit` while in PENDING is ignored, so there is no double commit.
- Write and `i_Commit` in the same IDLE cycle: the write is accepted and is included in the commit.
- `i_Commit` and `i_SampleReady` in the same IDLE cycle: no copy at this boundary. The copy waits for the next `i_SampleReady`.
- The copy is a single-edge, full-bank transfer; there is no partial copy.
- Live-bank readback:
  - Waveform is returned zero-extended to 16 bits.
  - EnvelopeLevel is returned raw.
  - Operator ≥ 6 or field 3 returns 0.
- Reset mid-PENDING abandons the commit: state returns to IDLE and no `o_CommitDone` is issued.

## Timing
- Reset values:
  - Both banks: all fields 0.
  - `o_Config`: all 0.
  - Outputs: `o_WriteReady` 0 during reset, then 1 on the first cycle after reset releases. `o_WriteError`, `o_CommitPending`, `o_CommitDone`, `o_ReadValid` and `o_ReadData` are all 0.
- Write latency: the shadow entry is updated at the accept edge. `o_WriteError` is high for the following cycle only.
- Commit latency:
  - `o_CommitPending` rises the cycle after `i_Commit`.
  - The live bank and `o_Config` change at the edge that samples `i_SampleReady` = 1 in PENDING. The core's slot 0 of the next sample therefore sees the new values.
  - `o_CommitDone` and `o_WriteReady` go high, and `o_CommitPending` goes low, on the cycle after that edge. `o_CommitDone` lasts 1 cycle.
- Worst-case commit wait: 96 cycles (one full sample).
- Readback:
  - 1-cycle latency: `o_ReadValid` and `o_ReadData` are registered.
  - A read on the copy edge returns the pre-copy live value.
  - `o_ReadData` holds its last value when `o_ReadValid` = 0.
- `o_Config` is purely registered, with no combinational path from any input.

## Test plan
- Reset check: hold `i_Reset` = 0 for 3 cycles, then release → `o_Config` all 0, `o_WriteReady` 1, readback of voice 3 op 2 field 0 returns 0.
- Basic commit: write PhaseStep = 0x1234 to voice 5 op 1, then commit, then drive `i_SampleReady` after 40 cycles → `o_Config` unchanged until that edge, equal to 0x1234 after it, `o_CommitDone` high for exactly 1 cycle, readback returns 0x1234.
- Atomicity: commit, then hold `i_WriteValid` with EnvelopeLevel = 0x7FFF while PENDING → `o_WriteReady` stays 0 until the copy, the held write is accepted the cycle after `o_CommitDone` rises, and it is absent from the live bank until a second commit.
- Same-cycle events: `i_Commit` and `i_SampleReady` together → no copy; the next `i_SampleReady` 96 cycles later performs the copy.
- Invalid writes: write op 6, then write field 3 → each accepted with one `o_WriteError` pulse, a commit leaves live unchanged, and readback of op 6 returns 0.
- Reset mid-PENDING: write Waveform = 1 to voice 0 op 0, commit, then assert `i_Reset` before any `i_SampleReady` → no `o_CommitDone`, `o_CommitPending` 0, and the next `i_SampleReady` changes nothing.
